// File: rtl/alu8_pkg.sv
// Shared definitions for the alu8 datapath and its round-robin scheduler.
// Opcodes, flag bit positions and scheduler FSM encoding.
package alu8_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_SHR  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    localparam int FLG_Z = 0;
    localparam int FLG_C = 1;
    localparam int FLG_V = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
    } alu_req_t;

endpackage

// File: rtl/alu8.sv
// 8-bit combinational ALU with Z/C/V flags.
// C is carry, borrow or shifted-out bit; V only on ADD/SUB.
module alu8
    import alu8_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] op,
    output logic [7:0] y,
    output logic [2:0] flags
);

    logic c;
    logic v;

    always_comb begin
        y = '0;
        c = 1'b0;
        v = 1'b0;
        unique case (op)
            OP_ADD: begin
                {c, y} = {1'b0, a} + {1'b0, b};
                v = (a[7] == b[7]) && (y[7] != a[7]);
            end
            OP_SUB: begin
                y = a - b;
                c = a < b;
                v = (a[7] != b[7]) && (y[7] != a[7]);
            end
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_SHL: begin
                y = {a[6:0], 1'b0};
                c = a[7];
            end
            OP_SHR: begin
                y = {1'b0, a[7:1]};
                c = a[0];
            end
            default: y = a;
        endcase
    end

    assign flags[FLG_Z] = (y == 8'h00);
    assign flags[FLG_C] = c;
    assign flags[FLG_V] = v;

endmodule

// File: rtl/alu8_rr_arb.sv
// Combinational round-robin pick: first valid requester at or after ptr.
// Returns one-hot grant, its index, and whether anything was picked.
module alu8_rr_arb #(
    parameter int NREQ = 2,
    parameter int ID_W = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] gid,
    output logic            any
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [ID_W:0]     sum;

    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[NREQ-1:0];
        sum = '0;
        any = 1'b0;
        // walk downward so the lowest rotated offset is the final winner
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = {1'b0, ptr} + (ID_W+1)'(k);
                any = 1'b1;
            end
        end
        if (sum >= (ID_W+1)'(NREQ))
            sum = sum - (ID_W+1)'(NREQ);
        gid = sum[ID_W-1:0];
        grant = '0;
        for (int j = 0; j < NREQ; j++)
            grant[j] = any && (gid == ID_W'(j));
    end

endmodule

// File: rtl/alu8_arb.sv
// Round-robin scheduler sharing one alu8 among NREQ requesters.
// Optional per-requester grant counters under ALU8_ARB_STATS_EN.
module alu8_arb
    import alu8_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int ID_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*8-1:0] req_a,
    input  logic [NREQ*8-1:0] req_b,
    input  logic [NREQ*3-1:0] req_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ID_W-1:0]   rsp_id,
    output logic [7:0]        rsp_y,
    output logic [2:0]        rsp_flags
`ifdef ALU8_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0] grant_cnt
`endif
);

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] gid;
    logic [ID_W-1:0] nxt_ptr;
    logic [ID_W-1:0] lat_id;
    logic [NREQ-1:0] grant;
    logic            any;
    logic            accept;
    alu_req_t        sel;
    alu_req_t        lat;
    logic [7:0]      y;
    logic [2:0]      flags;

    alu8_rr_arb #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .gid   (gid),
        .any   (any)
    );

    alu8 u_alu (
        .a     (lat.a),
        .b     (lat.b),
        .op    (lat.op),
        .y     (y),
        .flags (flags)
    );

    assign req_ready = (rst_n && state == IDLE) ? grant : '0;
    assign accept    = (state == IDLE) && any;
    assign nxt_ptr   = (gid == ID_W'(NREQ - 1)) ? '0 : gid + ID_W'(1);

    always_comb begin
        sel = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (gid == ID_W'(j)) begin
                sel.a  = req_a[8*j +: 8];
                sel.b  = req_b[8*j +: 8];
                sel.op = req_op[3*j +: 3];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            lat       <= '0;
            lat_id    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_y     <= '0;
            rsp_flags <= '0;
        end else begin
            unique case (state)
                IDLE: if (accept) begin
                    lat    <= sel;
                    lat_id <= gid;
                    rr_ptr <= nxt_ptr;
                    state  <= EXEC;
                end
                EXEC: begin
                    rsp_y     <= y;
                    rsp_flags <= flags;
                    rsp_id    <= lat_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU8_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_cnt <= '0;
        end else begin
            for (int j = 0; j < NREQ; j++) begin
                if (req_ready[j] && req_valid[j] &&
                    grant_cnt[16*j +: 16] != 16'hFFFF)
                    grant_cnt[16*j +: 16] <= grant_cnt[16*j +: 16] + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu8_arb.sv
// Scoreboard bench for alu8_arb: directed scenarios then random traffic.
// Expected responses come from an arithmetic ALU model and a list-based RR model.
module tb_alu8_arb;

    localparam int NREQ = 3;
    localparam int ID_W = 2;

    typedef struct {
        int id;
        int y;
        int f;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*8-1:0] req_a;
    logic [NREQ*8-1:0] req_b;
    logic [NREQ*3-1:0] req_op;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ID_W-1:0]   rsp_id;
    logic [7:0]        rsp_y;
    logic [2:0]        rsp_flags;
`ifdef ALU8_ARB_STATS_EN
    logic [NREQ*16-1:0] grant_cnt;
`endif

    logic [NREQ-1:0] v = '0;
    logic [7:0]      ra [NREQ];
    logic [7:0]      rb [NREQ];
    logic [2:0]      rop [NREQ];

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    int   glog[$];
    bit   log_en = 0;
    int   ptr = 0;
    int   age = 0;
    bit   busy = 0;
    bit   rst_prev = 1;
    logic [NREQ-1:0] acc = '0;
    int   cnt [NREQ];

    assign req_valid = v;
    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign req_a[8*g +: 8]  = ra[g];
        assign req_b[8*g +: 8]  = rb[g];
        assign req_op[3*g +: 3] = rop[g];
    end

    alu8_arb #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) dut (
`ifdef ALU8_ARB_STATS_EN
        .grant_cnt (grant_cnt),
`endif
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .rsp_flags (rsp_flags)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(int id, int a, int b, int op);
        exp_t m;
        int y, c, ov, sa, sb, s;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        c = 0;
        ov = 0;
        case (op)
            0: begin y = a + b; c = (y > 255); s = sa + sb; ov = (s > 127 || s < -128); end
            1: begin y = a - b; c = (a < b);   s = sa - sb; ov = (s > 127 || s < -128); end
            2: y = a & b;
            3: y = a | b;
            4: y = a ^ b;
            5: begin y = a * 2; c = (a >= 128); end
            6: begin y = a / 2; c = a % 2; end
            default: y = a;
        endcase
        y = y & 255;
        m.id = id;
        m.y = y;
        m.f = (ov << 2) | (c << 1) | ((y == 0) ? 1 : 0);
        return m;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        int w, ai, idx;
        if (!rst_prev) begin
            chk("rst_rsp_valid", int'(rsp_valid), 0);
            chk("rst_rsp_y", int'(rsp_y), 0);
            chk("rst_rsp_flags", int'(rsp_flags), 0);
            chk("rst_rsp_id", int'(rsp_id), 0);
        end
        if (!rst_n) begin
            chk("rst_req_ready", int'(req_ready), 0);
            q.delete();
            busy = 0;
            ptr = 0;
            age = 0;
            acc = '0;
            for (int r = 0; r < NREQ; r++) cnt[r] = 0;
        end else begin
            if (busy) age++;
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
                idx = (ptr + k) % NREQ;
                if (w < 0 && req_valid[idx]) w = idx;
            end
            chk("req_ready", int'(req_ready), (busy || w < 0) ? 0 : (1 << w));
            chk("ready_onehot", int'($countones(req_ready) <= 1), 1);
            chk("rsp_valid", int'(rsp_valid), int'(busy && age >= 2));
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    chk("rsp_id", int'(rsp_id), q[0].id);
                    chk("rsp_y", int'(rsp_y), q[0].y);
                    chk("rsp_flags", int'(rsp_flags), q[0].f);
                    if (rsp_ready) begin
                        void'(q.pop_front());
                        busy = 0;
                    end
                end
            end
            ai = -1;
            for (int k = 0; k < NREQ; k++)
                if (ai < 0 && req_ready[k] && req_valid[k]) ai = k;
            if (ai >= 0) begin
                q.push_back(model(ai, int'(ra[ai]), int'(rb[ai]), int'(rop[ai])));
                acc[ai] = 1'b1;
                ptr = (ai + 1) % NREQ;
                busy = 1;
                age = 0;
                cnt[ai]++;
                if (log_en) glog.push_back(ai);
            end
        end
        rst_prev = rst_n;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        v = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int r, input int a, input int b, input int op);
        ra[r]  = 8'(a);
        rb[r]  = 8'(b);
        rop[r] = 3'(op);
        v[r]   = 1'b1;
    endtask

    task automatic wait_acc(input int r, input bit hold);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!acc[r] && n < 40);
        if (!acc[r]) chk("accept_timeout", r, -1);
        acc[r] = 1'b0;
        if (!hold) v[r] = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        chk("drain_idle", int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, r;
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = '0;
            rb[i] = '0;
            rop[i] = '0;
        end
        tick();
        tick();
        tick();
        rst_n = 1'b1;

        set_req(0, 'h7F, 'h01, 0);
        wait_acc(0, 0);
        wait_idle();

        do_reset();
        set_req(0, 'h00, 'h01, 1);
        set_req(1, 'hF0, 'h0F, 2);
        wait_acc(0, 0);
        wait_acc(1, 0);
        wait_idle();

        do_reset();
        log_en = 1;
        for (int i = 0; i < NREQ; i++)
            set_req(i, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 7));
        for (int g = 0; g < 6; g++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (acc == '0 && n < 40);
            if (acc == '0) chk("rr_timeout", g, -1);
            r = 0;
            for (int k = 0; k < NREQ; k++) if (acc[k]) r = k;
            acc = '0;
            set_req(r, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 7));
        end
        v = '0;
        log_en = 0;
        wait_idle();
        chk("rr_count", glog.size(), 6);
        for (int k = 0; k < glog.size(); k++) chk("rr_order", glog[k], k % 3);

        set_req(1, 'h81, $urandom_range(0, 255), 5);
        wait_acc(1, 0);
        rsp_ready = 1'b0;
        set_req(0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 7));
        n = 0;
        while (!rsp_valid && n < 10) begin
            tick();
            n++;
        end
        repeat (5) tick();
        rsp_ready = 1'b1;
        wait_acc(0, 0);
        wait_idle();

        set_req(0, 'h55, 'h00, 7);
        wait_acc(0, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        set_req(1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 7));
        set_req(0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 7));
        wait_acc(0, 0);
        wait_acc(1, 0);
        wait_idle();

        for (int c = 0; c < 400; c++) begin
            tick();
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) begin
                    acc[i] = 1'b0;
                    v[i] = 1'b0;
                end
                if (!v[i] && $urandom_range(0, 2) == 0)
                    set_req(i, $urandom_range(0, 255), $urandom_range(0, 255),
                            $urandom_range(0, 7));
                else if (v[i] && $urandom_range(0, 15) == 0)
                    v[i] = 1'b0;
            end
        end
        v = '0;
        rsp_ready = 1'b1;
        wait_idle();
        acc = '0;

`ifdef ALU8_ARB_STATS_EN
        for (int i = 0; i < NREQ; i++)
            chk("grant_cnt_rand", int'((grant_cnt >> (16 * i)) & 16'hFFFF), cnt[i]);
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_req(1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 7));
            wait_acc(1, 0);
            wait_idle();
        end
        chk("grant_cnt1", int'(grant_cnt[31:16]), 4);
        chk("grant_cnt0", int'(grant_cnt[15:0]), 0);
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
